exec_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute/writeback controller for the 16-bit CPU. It sits directly upstream and downstream of the ALU. It fetches instructions over a simple request/acknowledge port, reads an internal 8×16 register file, and drives `alu_code`, `reg_data1` and `reg_data2`. It then consumes `accum` and `branch_check` to write results back and update the PC.

---
 rtl/exec_sequencer_if.sv | 20 ++
 rtl/exec_sequencer.sv | 81 ++++++++
 tb/tb_exec_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: instruction-fetch port and ALU operand/result bundle
interface exec_sequencer_if #(parameter int PC_W = 8);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;
  logic [3:0]      alu_code;
  logic [15:0]     reg_data1;
  logic [15:0]     reg_data2;
  logic [15:0]     accum;
  logic            branch_check;
  modport master (
    output imem_req, imem_addr, alu_code, reg_data1, reg_data2,
    input  imem_ack, imem_rdata, accum, branch_check
  );
  modport slave (
    input  imem_req, imem_addr, alu_code, reg_data1, reg_data2,
    output imem_ack, imem_rdata, accum, branch_check
  );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/decode/execute/writeback controller around an external ALU
module exec_sequencer #(
  parameter int PC_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  exec_sequencer_if.master    bus,
  output logic                instr_done,
  output logic                halted,
  input  logic [2:0]          dbg_sel,
  output logic [15:0]         dbg_data
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
  state_t          state, state_nx;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [15:0]     res;
  logic            take;
  logic [15:0]     rf [8];
  logic [3:0]      op;
  logic            is_alu, is_br, is_li;
  logic [2:0]      rd, rs1, rs2;
  assign op       = ir[15:12];
  assign is_alu   = op == 4'b1000 || op == 4'b0100;
  assign is_br    = op == 4'b1100 || op == 4'b1101 || op == 4'b1110;
  assign is_li    = op == 4'b0001;
  assign rd       = ir[11:9];
  assign rs1      = is_alu ? ir[8:6] : ir[11:9];
  assign rs2      = is_alu ? ir[5:3] : ir[8:6];
  assign bus.imem_req  = rst_n && state == FETCH;
  assign bus.imem_addr = pc;
  assign halted   = state == HALT;
  assign dbg_data = rf[dbg_sel];
  // next-state selection; HALT only leaves through reset
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:     state_nx = bus.imem_ack ? DECODE : FETCH;
      DECODE:    state_nx = EXECUTE;
      EXECUTE:   state_nx = op == 4'b0000 ? HALT : WRITEBACK;
      WRITEBACK: state_nx = FETCH;
      default:   state_nx = HALT;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nx;
  end
  // datapath: IR latch, operand registers, result capture, writeback and PC update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= '0;
      ir            <= '0;
      res           <= '0;
      take          <= 1'b0;
      instr_done    <= 1'b0;
      bus.alu_code  <= '0;
      bus.reg_data1 <= '0;
      bus.reg_data2 <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      instr_done <= state == EXECUTE;
      if (state == FETCH && bus.imem_ack) ir <= bus.imem_rdata;
      if (state == DECODE) begin
        bus.alu_code  <= op;
        bus.reg_data1 <= (is_alu || is_br) ? rf[rs1] : '0;
        bus.reg_data2 <= (is_alu || is_br) ? rf[rs2] : '0;
      end
      if (state == EXECUTE) begin
        res  <= bus.accum;
        take <= bus.branch_check;
      end
      if (state == WRITEBACK) begin
        if (is_alu)     rf[rd] <= res;
        else if (is_li) rf[rd] <= {7'd0, ir[8:0]};
        pc <= pc + PC_W'(1) + ((is_br && take) ? PC_W'($signed(ir[5:0])) : '0);
      end
    end
  end
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: randomized and directed checks against an instruction-level model
`timescale 1ns/1ps
module tb_exec_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_done, halted;
  logic [2:0]  dbg_sel = 3'd0;
  logic [15:0] dbg_data;
  logic [15:0] mem [256];
  int          ack_delay = 0;
  logic        force_ack = 1'b0;
  int          wcnt;
  int          passed = 0;
  int          total = 0;
  logic [15:0] m_rf [8];
  logic [7:0]  m_pc;
  localparam logic [15:0] JUNK = 16'h1FFF;
  always #10 clk = ~clk;
  exec_sequencer_if #(.PC_W(8)) bus();
  exec_sequencer #(.PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .instr_done(instr_done),
    .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );
  // instruction memory with programmable wait states
  always @(posedge clk or negedge rst_n)
    if (!rst_n) wcnt <= 0;
    else        wcnt <= (bus.imem_req && !bus.imem_ack) ? wcnt + 1 : 0;
  assign bus.imem_ack   = (bus.imem_req && wcnt >= ack_delay) || force_ack;
  assign bus.imem_rdata = (bus.imem_req && wcnt >= ack_delay) ? mem[bus.imem_addr] : JUNK;
  // ALU stand-in; unknown codes return values that would corrupt state if misused
  assign bus.accum = bus.alu_code == 4'h8 ? bus.reg_data1 + bus.reg_data2 :
                     bus.alu_code == 4'h4 ? bus.reg_data1 - bus.reg_data2 : 16'hA5A5;
  assign bus.branch_check = bus.alu_code == 4'hC ? bus.reg_data1 == bus.reg_data2 :
                            bus.alu_code == 4'hD ? $signed(bus.reg_data1) < $signed(bus.reg_data2) :
                            bus.alu_code == 4'hE ? $signed(bus.reg_data1) > $signed(bus.reg_data2) : 1'b1;
  function automatic logic [15:0] enc_alu(logic [3:0] o, logic [2:0] d, logic [2:0] s1, logic [2:0] s2);
    return {o, d, s1, s2, 3'd0};
  endfunction
  function automatic logic [15:0] enc_li(logic [2:0] d, logic [8:0] imm);
    return {4'h1, d, imm};
  endfunction
  function automatic logic [15:0] enc_br(logic [3:0] o, logic [2:0] s1, logic [2:0] s2, logic [5:0] off);
    return {o, s1, s2, off};
  endfunction
  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask
  task automatic apply_reset(input int d);
    rst_n = 1'b0;
    force_ack = 1'b0;
    ack_delay = d;
    dbg_sel = 3'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (instr_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic run_n(input int n, output bit ok);
    bit o;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_done(o);
      if (!o) begin
        ok = 1'b0;
        break;
      end
    end
  endtask
  // instruction-set reference: executes one instruction from mem at m_pc
  task automatic model_step;
    logic [15:0] w, a, b;
    logic [3:0]  o;
    logic        t;
    w = mem[m_pc];
    o = w[15:12];
    if (o == 4'h8 || o == 4'h4) begin
      a = m_rf[w[8:6]];
      b = m_rf[w[5:3]];
      m_rf[w[11:9]] = o == 4'h8 ? a + b : a - b;
      m_pc = m_pc + 8'd1;
    end else if (o == 4'h1) begin
      m_rf[w[11:9]] = {7'd0, w[8:0]};
      m_pc = m_pc + 8'd1;
    end else if (o >= 4'hC && o <= 4'hE) begin
      a = m_rf[w[11:9]];
      b = m_rf[w[8:6]];
      t = o == 4'hC ? a == b : o == 4'hD ? $signed(a) < $signed(b) : $signed(a) > $signed(b);
      m_pc = m_pc + 8'd1 + (t ? {{2{w[5]}}, w[5:0]} : 8'd0);
    end else begin
      m_pc = m_pc + 8'd1;
    end
  endtask
  task automatic test_reset;
    clear_mem();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", bus.imem_req); else passed++;
    total++; if (bus.alu_code !== 4'h0) $display("FAIL reset_code got %h want 0", bus.alu_code); else passed++;
    total++; if ({bus.reg_data1, bus.reg_data2} !== 32'h0) $display("FAIL reset_ops got %h/%h want 0/0", bus.reg_data1, bus.reg_data2); else passed++;
    total++; if ({instr_done, halted} !== 2'b00) $display("FAIL reset_flags got %b want 00", {instr_done, halted}); else passed++;
    for (int r = 0; r < 8; r++) begin
      dbg_sel = 3'(r);
      #1;
      total++; if (dbg_data !== 16'h0) $display("FAIL reset_rf r%0d got %h want 0", r, dbg_data); else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) $display("FAIL reset_release got req=%b addr=%h want 1/00", bus.imem_req, bus.imem_addr); else passed++;
  endtask
  task automatic test_load_add;
    int cnt;
    clear_mem();
    mem[0] = enc_li(3'd1, 9'd5);
    mem[1] = enc_li(3'd2, 9'd3);
    mem[2] = enc_alu(4'h8, 3'd3, 3'd1, 3'd2);
    apply_reset(0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (instr_done) cnt++;
    end
    total++; if (cnt !== 3) $display("FAIL load_add_pulses got %0d want 3", cnt); else passed++;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd3) $display("FAIL load_add_pc got %h want 03", bus.imem_addr); else passed++;
    dbg_sel = 3'd3;
    #1;
    total++; if (dbg_data !== 16'h0008) $display("FAIL load_add_r3 got %h want 0008", dbg_data); else passed++;
  endtask
  task automatic test_sub_wrap;
    bit ok;
    clear_mem();
    mem[0] = enc_li(3'd1, 9'd3);
    mem[1] = enc_li(3'd2, 9'd5);
    mem[2] = enc_alu(4'h4, 3'd4, 3'd1, 3'd2);
    apply_reset(0);
    run_n(2, ok);
    total++; if (!ok) $display("FAIL sub_timeout got no instr_done want 2 pulses"); else passed++;
    repeat (3) @(negedge clk);
    total++; if (bus.reg_data1 !== 16'd3 || bus.reg_data2 !== 16'd5 || bus.alu_code !== 4'h4)
      $display("FAIL sub_operands got %h/%h code %h want 0003/0005 code 4", bus.reg_data1, bus.reg_data2, bus.alu_code); else passed++;
    wait_done(ok);
    @(negedge clk);
    dbg_sel = 3'd4;
    #1;
    total++; if (!ok || dbg_data !== 16'hFFFE) $display("FAIL sub_r4 got %h want fffe", dbg_data); else passed++;
  endtask
  task automatic test_branches;
    bit ok;
    logic [15:0] exp_r;
    clear_mem();
    mem[0] = enc_li(3'd1, 9'd7);
    for (int i = 1; i < 10; i++) mem[i] = {4'hF, 3'(i), 9'h1B6};
    mem[10] = enc_br(4'hC, 3'd1, 3'd1, 6'b111110);
    apply_reset(0);
    run_n(11, ok);
    @(negedge clk);
    total++; if (!ok || bus.imem_addr !== 8'd9) $display("FAIL beq_back got %h want 09", bus.imem_addr); else passed++;
    for (int r = 0; r < 8; r++) begin
      dbg_sel = 3'(r);
      #1;
      exp_r = r == 1 ? 16'd7 : 16'd0;
      total++; if (dbg_data !== exp_r) $display("FAIL nop_rf r%0d got %h want %h", r, dbg_data, exp_r); else passed++;
    end
    clear_mem();
    for (int i = 0; i < 10; i++) mem[i] = 16'hF000;
    mem[10] = enc_br(4'hD, 3'd1, 3'd2, 6'd5);
    apply_reset(0);
    run_n(11, ok);
    @(negedge clk);
    total++; if (!ok || bus.imem_addr !== 8'd11) $display("FAIL blt_not_taken got %h want 0b", bus.imem_addr); else passed++;
    clear_mem();
    mem[0] = enc_li(3'd1, 9'd9);
    for (int i = 1; i < 255; i++) mem[i] = 16'hF000;
    mem[255] = enc_br(4'hE, 3'd1, 3'd2, 6'd1);
    apply_reset(0);
    run_n(256, ok);
    @(negedge clk);
    total++; if (!ok || bus.imem_addr !== 8'd1) $display("FAIL bgt_wrap got %h want 01", bus.imem_addr); else passed++;
  endtask
  task automatic test_wait_states;
    int first_done, stable;
    bit ok;
    clear_mem();
    mem[0] = enc_li(3'd1, 9'd5);
    apply_reset(3);
    first_done = -1;
    stable = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n <= 3 && bus.imem_req && bus.imem_addr == 8'd0 && !instr_done) stable++;
      if (instr_done && first_done < 0) first_done = n;
    end
    total++; if (stable !== 3) $display("FAIL wait_req_hold got %0d want 3", stable); else passed++;
    total++; if (first_done !== 6) $display("FAIL wait_done_cycle got %0d want 6", first_done); else passed++;
    clear_mem();
    mem[0] = enc_li(3'd1, 9'd5);
    mem[1] = enc_li(3'd2, 9'd6);
    apply_reset(0);
    repeat (2) @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    total++; if (instr_done !== 1'b1) $display("FAIL spurious_ack_done got %b want 1", instr_done); else passed++;
    wait_done(ok);
    @(negedge clk);
    total++; if (!ok || bus.imem_addr !== 8'd2) $display("FAIL spurious_ack_pc got %h want 02", bus.imem_addr); else passed++;
    dbg_sel = 3'd7;
    #1;
    total++; if (dbg_data !== 16'h0) $display("FAIL spurious_ack_r7 got %h want 0000", dbg_data); else passed++;
    dbg_sel = 3'd2;
    #1;
    total++; if (dbg_data !== 16'd6) $display("FAIL spurious_ack_r2 got %h want 0006", dbg_data); else passed++;
  endtask
  task automatic test_halt;
    bit ok;
    int bad;
    clear_mem();
    mem[0] = enc_li(3'd1, 9'd5);
    mem[1] = 16'h0000;
    mem[2] = enc_li(3'd1, 9'd9);
    apply_reset(0);
    run_n(2, ok);
    total++; if (!ok || halted !== 1'b1) $display("FAIL halt_entry got halted=%b want 1", halted); else passed++;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (halted !== 1'b1 || bus.imem_req !== 1'b0 || instr_done !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL halt_hold got %0d bad cycles want 0", bad); else passed++;
    dbg_sel = 3'd1;
    #1;
    total++; if (dbg_data !== 16'd5) $display("FAIL halt_rf got %h want 0005", dbg_data); else passed++;
  endtask
  task automatic test_reset_mid;
    bit ok;
    clear_mem();
    mem[0] = enc_li(3'd1, 9'd5);
    mem[1] = enc_li(3'd2, 9'd3);
    mem[2] = enc_alu(4'h8, 3'd3, 3'd1, 3'd2);
    apply_reset(0);
    run_n(2, ok);
    repeat (3) @(negedge clk);
    total++; if (!ok || bus.alu_code !== 4'h8) $display("FAIL mid_pre got code %h want 8", bus.alu_code); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (bus.imem_req !== 1'b0 || bus.alu_code !== 4'h0 || bus.reg_data1 !== 16'h0 || bus.reg_data2 !== 16'h0 || instr_done !== 1'b0 || halted !== 1'b0)
      $display("FAIL mid_outputs got req=%b code=%h ops=%h/%h done=%b halted=%b want all 0", bus.imem_req, bus.alu_code, bus.reg_data1, bus.reg_data2, instr_done, halted); else passed++;
    dbg_sel = 3'd3;
    #1;
    total++; if (dbg_data !== 16'h0) $display("FAIL mid_r3 got %h want 0000", dbg_data); else passed++;
    dbg_sel = 3'd1;
    #1;
    total++; if (dbg_data !== 16'h0) $display("FAIL mid_r1 got %h want 0000", dbg_data); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.imem_addr !== 8'd0 || bus.imem_req !== 1'b1) $display("FAIL mid_pc got %h want 00", bus.imem_addr); else passed++;
  endtask
  task automatic test_random;
    bit ok;
    for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(1, 15)), 12'($urandom)};
    for (int r = 0; r < 8; r++) m_rf[r] = 16'h0;
    m_pc = 8'd0;
    apply_reset(0);
    for (int k = 0; k < 80; k++) begin
      wait_done(ok);
      total++;
      if (!ok) begin
        $display("FAIL random_timeout got no instr_done at instr %0d want pulse", k);
        break;
      end
      passed++;
      model_step();
      ack_delay = $urandom_range(0, 3);
      @(negedge clk);
      total++; if (bus.imem_addr !== m_pc) $display("FAIL random_pc instr %0d got %h want %h", k, bus.imem_addr, m_pc); else passed++;
      for (int r = 0; r < 8; r++) begin
        dbg_sel = 3'(r);
        #1;
        total++; if (dbg_data !== m_rf[r]) $display("FAIL random_rf instr %0d r%0d got %h want %h", k, r, dbg_data, m_rf[r]); else passed++;
      end
    end
  endtask
  initial begin
    test_reset();
    test_load_add();
    test_sub_wrap();
    test_branches();
    test_wait_states();
    test_halt();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
